// File: rtl/axi_riscv_amo_pkg.sv
// Shared types for the RISC-V atomic AXI initiator: op encoding, ATOP codes,
// and the default AXI5 request/response structs it drives.
package axi_riscv_amo_pkg;

  localparam int unsigned AxiAddrW = 64;
  localparam int unsigned AxiDataW = 64;
  localparam int unsigned AxiIdW   = 4;
  localparam int unsigned AxiUserW = 1;

  typedef enum logic [3:0] {
    OP_LR   = 4'd0,
    OP_SC   = 4'd1,
    OP_SWAP = 4'd2,
    OP_ADD  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_MAX  = 4'd7,
    OP_MAXU = 4'd8,
    OP_MIN  = 4'd9,
    OP_MINU = 4'd10
  } amo_op_e;

  localparam logic [3:0] OP_LAST = 4'd10;

  localparam logic [5:0] ATOP_NONE = 6'b000000;
  localparam logic [5:0] ATOP_SWAP = 6'b110000;
  localparam logic [5:0] ATOP_ADD  = 6'b100000;
  localparam logic [5:0] ATOP_CLR  = 6'b100001;
  localparam logic [5:0] ATOP_EOR  = 6'b100010;
  localparam logic [5:0] ATOP_SET  = 6'b100011;
  localparam logic [5:0] ATOP_SMAX = 6'b100100;
  localparam logic [5:0] ATOP_SMIN = 6'b100101;
  localparam logic [5:0] ATOP_UMAX = 6'b100110;
  localparam logic [5:0] ATOP_UMIN = 6'b100111;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef struct packed {
    logic [5:0] atop;
    logic       invert;
  } atop_map_t;

  // AND is issued as CLR, so the operand must be inverted on W.
  function automatic atop_map_t amo_to_atop(input amo_op_e op);
    atop_map_t m;
    m.invert = 1'b0;
    case (op)
      OP_SWAP: m.atop = ATOP_SWAP;
      OP_ADD:  m.atop = ATOP_ADD;
      OP_AND:  begin m.atop = ATOP_CLR; m.invert = 1'b1; end
      OP_OR:   m.atop = ATOP_SET;
      OP_XOR:  m.atop = ATOP_EOR;
      OP_MAX:  m.atop = ATOP_SMAX;
      OP_MAXU: m.atop = ATOP_UMAX;
      OP_MIN:  m.atop = ATOP_SMIN;
      OP_MINU: m.atop = ATOP_UMIN;
      default: m.atop = ATOP_NONE;
    endcase
    return m;
  endfunction

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [5:0]          atop;
    logic [AxiUserW-1:0] user;
  } amo_aw_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [AxiUserW-1:0] user;
  } amo_ar_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
    logic [AxiUserW-1:0]   user;
  } amo_w_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [1:0]          resp;
    logic [AxiUserW-1:0] user;
  } amo_b_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
    logic [AxiUserW-1:0] user;
  } amo_r_chan_t;

  typedef struct packed {
    amo_aw_chan_t aw;
    logic         aw_valid;
    amo_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    amo_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } amo_axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    amo_b_chan_t b;
    logic        r_valid;
    amo_r_chan_t r;
  } amo_axi_rsp_t;

endpackage

// File: rtl/axi_riscv_amo_lane.sv
// Byte-lane helper: W replication/strobes for a word or doubleword at a bus
// offset, and R lane extraction with 32-bit sign extension.
module axi_riscv_amo_lane #(
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned RiscvWordWidth = 64,
  parameter int unsigned AxiAddrLSB     = 3
) (
  input  logic [AxiAddrLSB-1:0]     addr_lsb_i,
  input  logic [1:0]                size_i,
  input  logic [RiscvWordWidth-1:0] operand_i,
  input  logic                      invert_i,
  input  logic [AxiDataWidth-1:0]   rdata_bus_i,
  output logic [AxiDataWidth-1:0]   wdata_o,
  output logic [AxiDataWidth/8-1:0] strb_o,
  output logic [RiscvWordWidth-1:0] rdata_o
);

  logic [63:0]             op64;
  logic [AxiDataWidth-1:0] shifted;
  int unsigned             lsb;
  int unsigned             nbytes;

  always_comb begin
    op64    = 64'(operand_i);
    lsb     = 32'(addr_lsb_i);
    nbytes  = (size_i == 2'd3) ? 32'd8 : 32'd4;
    wdata_o = '0;
    strb_o  = '0;
    for (int unsigned i = 0; i < AxiDataWidth / 32; i++) begin
      wdata_o[i*32 +: 32] = (size_i == 2'd3) ? op64[(i % 2)*32 +: 32] : op64[31:0];
    end
    if (invert_i) wdata_o = ~wdata_o;
    for (int unsigned i = 0; i < AxiDataWidth / 8; i++) begin
      strb_o[i] = (i >= lsb) && (i < lsb + nbytes);
    end
    shifted = rdata_bus_i >> {addr_lsb_i, 3'b000};
    rdata_o = (size_i == 2'd3) ? shifted[RiscvWordWidth-1:0]
                               : RiscvWordWidth'($signed(shifted[31:0]));
  end

endmodule

// File: rtl/axi_riscv_amo_initiator.sv
// Issues one RISC-V LR/SC/AMO request at a time as an AXI5 transaction
// (exclusive AR/AW for LR/SC, ATOP on AW for AMOs) and returns the result.
module axi_riscv_amo_initiator
  import axi_riscv_amo_pkg::*;
#(
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned AxiUserWidth   = 1,
  parameter int unsigned AxiId          = 0,
  parameter int unsigned RiscvWordWidth = 64,
  parameter int unsigned AxiAddrLSB     = $clog2(AxiDataWidth / 8),
  parameter type         axi_req_t      = amo_axi_req_t,
  parameter type         axi_rsp_t      = amo_axi_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [3:0]                req_op_i,
  input  logic [AxiAddrWidth-1:0]   req_addr_i,
  input  logic [1:0]                req_size_i,
  input  logic [RiscvWordWidth-1:0] req_wdata_i,
  input  logic [AxiUserWidth-1:0]   req_user_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [RiscvWordWidth-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output axi_req_t                  axi_mst_req_o,
  input  axi_rsp_t                  axi_mst_rsp_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                    state_q, state_d;
  amo_op_e                   op_q, op_d;
  logic [AxiAddrWidth-1:0]   addr_q, addr_d;
  logic [1:0]                size_q, size_d;
  logic [RiscvWordWidth-1:0] wdata_q, wdata_d;
  logic [AxiUserWidth-1:0]   user_q, user_d;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                      b_seen_q, b_seen_d, r_seen_q, r_seen_d;
  logic                      err_q, err_d;
  logic [RiscvWordWidth-1:0] rdata_q, rdata_d;

  atop_map_t                 atop_map;
  logic [AxiDataWidth-1:0]   lane_wdata;
  logic [AxiDataWidth/8-1:0] lane_strb;
  logic [RiscvWordWidth-1:0] lane_rdata;
  logic [2:0]                align_mask;
  logic                      req_bad;
  logic                      done;
  logic                      unused_fields;

  assign atop_map      = amo_to_atop(op_q);
  assign unused_fields = ^{axi_mst_rsp_i.r.last, axi_mst_rsp_i.r.user, axi_mst_rsp_i.b.user};

  axi_riscv_amo_lane #(
    .AxiDataWidth   (AxiDataWidth),
    .RiscvWordWidth (RiscvWordWidth),
    .AxiAddrLSB     (AxiAddrLSB)
  ) u_lane (
    .addr_lsb_i  (addr_q[AxiAddrLSB-1:0]),
    .size_i      (size_q),
    .operand_i   (wdata_q),
    .invert_i    (atop_map.invert),
    .rdata_bus_i (axi_mst_rsp_i.r.data),
    .wdata_o     (lane_wdata),
    .strb_o      (lane_strb),
    .rdata_o     (lane_rdata)
  );

  always_comb begin
    align_mask = (req_size_i == 2'd3) ? 3'b111 : 3'b011;
    req_bad    = (req_op_i > OP_LAST) || (req_size_i < 2'd2)
              || ((req_size_i == 2'd3) && (RiscvWordWidth == 32))
              || (|(req_addr_i[2:0] & align_mask));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= OP_LR;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      user_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_seen_q  <= 1'b0;
      r_seen_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      user_q    <= user_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      b_seen_q  <= b_seen_d;
      r_seen_q  <= r_seen_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    user_d    = user_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    b_seen_d  = b_seen_q;
    r_seen_d  = r_seen_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          err_d     = req_bad;
          rdata_d   = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          b_seen_d  = 1'b0;
          r_seen_d  = 1'b0;
          if (req_bad) begin
            state_d = RESP;
          end else begin
            op_d    = amo_op_e'(req_op_i);
            addr_d  = req_addr_i;
            size_d  = req_size_i;
            wdata_d = req_wdata_i;
            user_d  = req_user_i;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_q == OP_LR) begin
          if (axi_mst_req_o.ar_valid && axi_mst_rsp_i.ar_ready) state_d = WAIT;
        end else begin
          aw_done_d = aw_done_q | (axi_mst_req_o.aw_valid & axi_mst_rsp_i.aw_ready);
          w_done_d  = w_done_q  | (axi_mst_req_o.w_valid  & axi_mst_rsp_i.w_ready);
          if (aw_done_d && w_done_d) state_d = WAIT;
        end
      end
      WAIT: begin
        // B and R are sticky so AMOs complete regardless of arrival order.
        if (axi_mst_rsp_i.b_valid) begin
          b_seen_d = 1'b1;
          if (axi_mst_rsp_i.b.resp[1]) err_d = 1'b1;
          if (op_q == OP_SC)
            rdata_d = (axi_mst_rsp_i.b.resp == RESP_EXOKAY) ? '0 : RiscvWordWidth'(1);
        end
        if (axi_mst_rsp_i.r_valid) begin
          r_seen_d = 1'b1;
          if (axi_mst_rsp_i.r.resp[1]) err_d = 1'b1;
          if (op_q != OP_SC) rdata_d = lane_rdata;
        end
        case (op_q)
          OP_SC:   done = b_seen_d;
          OP_LR:   done = r_seen_d;
          default: done = b_seen_d && r_seen_d;
        endcase
        if (done) begin
          state_d = RESP;
          if (err_d) rdata_d = '0;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi_mst_req_o = '0;
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_rdata_o   = '0;
    rsp_err_o     = 1'b0;
    case (state_q)
      IDLE: req_ready_o = !rst_i;
      ISSUE: begin
        if (op_q == OP_LR) begin
          axi_mst_req_o.ar_valid   = 1'b1;
          axi_mst_req_o.ar.id      = AxiIdWidth'(AxiId);
          axi_mst_req_o.ar.addr    = addr_q;
          axi_mst_req_o.ar.size    = {1'b0, size_q};
          axi_mst_req_o.ar.burst   = BURST_INCR;
          axi_mst_req_o.ar.lock    = 1'b1;
          axi_mst_req_o.ar.user    = user_q;
        end else begin
          axi_mst_req_o.aw_valid   = !aw_done_q;
          axi_mst_req_o.aw.id      = AxiIdWidth'(AxiId);
          axi_mst_req_o.aw.addr    = addr_q;
          axi_mst_req_o.aw.size    = {1'b0, size_q};
          axi_mst_req_o.aw.burst   = BURST_INCR;
          axi_mst_req_o.aw.lock    = (op_q == OP_SC);
          axi_mst_req_o.aw.atop    = atop_map.atop;
          axi_mst_req_o.aw.user    = user_q;
          axi_mst_req_o.w_valid    = !w_done_q;
          axi_mst_req_o.w.data     = lane_wdata;
          axi_mst_req_o.w.strb     = lane_strb;
          axi_mst_req_o.w.last     = 1'b1;
          axi_mst_req_o.w.user     = user_q;
        end
      end
      WAIT: begin
        axi_mst_req_o.b_ready = 1'b1;
        axi_mst_req_o.r_ready = 1'b1;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
      end
      default: ;
    endcase
  end

  a_b_id: assert property (@(posedge clk_i) disable iff (rst_i)
    (axi_mst_rsp_i.b_valid && axi_mst_req_o.b_ready) |-> (axi_mst_rsp_i.b.id == AxiIdWidth'(AxiId)));
  a_r_id: assert property (@(posedge clk_i) disable iff (rst_i)
    (axi_mst_rsp_i.r_valid && axi_mst_req_o.r_ready) |-> (axi_mst_rsp_i.r.id == AxiIdWidth'(AxiId)));

endmodule

// File: tb/tb_axi_riscv_amo_initiator.sv
// Directed bench for axi_riscv_amo_initiator with a scripted AXI subordinate.
module tb_axi_riscv_amo_initiator;
  import axi_riscv_amo_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_op_i;
  logic [63:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic [63:0] req_wdata_i;
  logic [0:0]  req_user_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  amo_axi_req_t axi_req;
  amo_axi_rsp_t axi_rsp;

  always #5 clk_i = ~clk_i;

  axi_riscv_amo_initiator #(
    .AxiAddrWidth   (64),
    .AxiDataWidth   (64),
    .AxiIdWidth     (4),
    .AxiUserWidth   (1),
    .AxiId          (0),
    .RiscvWordWidth (64),
    .axi_req_t      (amo_axi_req_t),
    .axi_rsp_t      (amo_axi_rsp_t)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_addr_i    (req_addr_i),
    .req_size_i    (req_size_i),
    .req_wdata_i   (req_wdata_i),
    .req_user_i    (req_user_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .axi_mst_req_o (axi_req),
    .axi_mst_rsp_i (axi_rsp)
  );

  int total = 0;
  int bad   = 0;

  int           aw_cnt, w_cnt, ar_cnt, rsp_cnt, rsp_cyc;
  logic         acc_rdy;
  logic [63:0]  rsp_dat;
  logic         rsp_e;
  amo_aw_chan_t aw_cap;
  amo_w_chan_t  w_cap;
  amo_ar_chan_t ar_cap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request; B/R are returned b_dly/r_dly cycles after the issue cycle's
  // follow-on cycle. Records what the DUT put on the bus and what it answered.
  task automatic run(input logic [3:0] op, input logic [63:0] addr, input logic [1:0] size,
                     input logic [63:0] wdata, input int r_dly, input int b_dly,
                     input logic [1:0] bresp, input logic [1:0] rresp, input logic [63:0] rbus);
    int issue_c = -1;
    int b_at    = -1;
    int r_at    = -1;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0; rsp_cyc = -1;
    rsp_dat = '0; rsp_e = 1'b0;
    aw_cap = '0; w_cap = '0; ar_cap = '0;
    acc_rdy     = req_ready_o;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_addr_i  = addr;
    req_size_i  = size;
    req_wdata_i = wdata;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (axi_req.aw_valid) begin aw_cnt++; aw_cap = axi_req.aw; end
      if (axi_req.w_valid)  begin w_cnt++;  w_cap  = axi_req.w;  end
      if (axi_req.ar_valid) begin ar_cnt++; ar_cap = axi_req.ar; end
      if (rsp_valid_o && rsp_ready_i) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin rsp_cyc = c; rsp_dat = rsp_rdata_o; rsp_e = rsp_err_o; end
      end
      if (issue_c < 0 && ((aw_cnt > 0 && w_cnt > 0) || ar_cnt > 0)) begin
        issue_c = c;
        b_at = (aw_cnt > 0) ? c + 1 + b_dly : -1;
        r_at = (ar_cnt > 0 || op >= 4'd2) ? c + 1 + r_dly : -1;
      end
      axi_rsp.b_valid = (c == b_at);
      axi_rsp.b.resp  = bresp;
      axi_rsp.r_valid = (c == r_at);
      axi_rsp.r.data  = rbus;
      axi_rsp.r.resp  = rresp;
      axi_rsp.r.last  = 1'b1;
      @(posedge clk_i); #1;
    end
    axi_rsp.b_valid = 1'b0;
    axi_rsp.r_valid = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_op_i    = '0;
    req_addr_i  = '0;
    req_size_i  = '0;
    req_wdata_i = '0;
    req_user_i  = '0;
    rsp_ready_i = 1'b1;
    axi_rsp     = '0;
    axi_rsp.aw_ready = 1'b1;
    axi_rsp.w_ready  = 1'b1;
    axi_rsp.ar_ready = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_axi_zero", (axi_req == '0), 1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("post_rst_ready", req_ready_o, 1);
    chk("post_rst_rsp_valid", rsp_valid_o, 0);
    chk("post_rst_axi_zero", (axi_req == '0), 1);

    // AMOADD.W at 0x1004: upper word lane carries the old value 7
    run(4'd3, 64'h1004, 2'd2, 64'h5, 0, 0, 2'b00, 2'b00, 64'h0000_0007_AAAA_BBBB);
    chk("add_acc_ready", acc_rdy, 1);
    chk("add_atop", aw_cap.atop, 6'b100000);
    chk("add_aw_lock", aw_cap.lock, 0);
    chk("add_aw_addr", aw_cap.addr, 64'h1004);
    chk("add_aw_size", aw_cap.size, 3'd2);
    chk("add_aw_cnt", aw_cnt, 1);
    chk("add_w_strb", w_cap.strb, 8'hF0);
    chk("add_w_data", w_cap.data, 64'h0000_0005_0000_0005);
    chk("add_w_last", w_cap.last, 1);
    chk("add_rsp_cyc", rsp_cyc, 3);
    chk("add_rdata", rsp_dat, 64'h7);
    chk("add_err", rsp_e, 0);
    chk("add_rsp_cnt", rsp_cnt, 1);

    // AMOMAX.W at 0x1000: low lane, negative value sign-extended
    run(4'd7, 64'h1000, 2'd2, 64'h1, 0, 0, 2'b00, 2'b00, 64'h1111_2222_8000_0001);
    chk("max_atop", aw_cap.atop, 6'b100100);
    chk("max_w_strb", w_cap.strb, 8'h0F);
    chk("max_rdata", rsp_dat, 64'hFFFF_FFFF_8000_0001);

    // AMOAND.D: CLR with inverted operand
    run(4'd4, 64'h2000, 2'd3, 64'hFF00, 0, 0, 2'b00, 2'b00, 64'h1234_5678_9ABC_DEF0);
    chk("and_atop", aw_cap.atop, 6'b100001);
    chk("and_w_data", w_cap.data, 64'hFFFF_FFFF_FFFF_00FF);
    chk("and_w_strb", w_cap.strb, 8'hFF);
    chk("and_rdata", rsp_dat, 64'h1234_5678_9ABC_DEF0);

    // R five cycles before B
    run(4'd5, 64'h2008, 2'd3, 64'h3, 0, 5, 2'b00, 2'b00, 64'h0102_0304_0506_0708);
    chk("or_atop", aw_cap.atop, 6'b100011);
    chk("r_first_cnt", rsp_cnt, 1);
    chk("r_first_cyc", rsp_cyc, 8);
    chk("r_first_rdata", rsp_dat, 64'h0102_0304_0506_0708);

    // B five cycles before R
    run(4'd6, 64'h2010, 2'd2, 64'h3, 5, 0, 2'b00, 2'b00, 64'h0000_0000_FFFF_FFFE);
    chk("xor_atop", aw_cap.atop, 6'b100010);
    chk("b_first_cnt", rsp_cnt, 1);
    chk("b_first_cyc", rsp_cyc, 8);
    chk("b_first_rdata", rsp_dat, 64'hFFFF_FFFF_FFFF_FFFE);

    // B and R in the same cycle
    run(4'd2, 64'h2018, 2'd3, 64'h9, 2, 2, 2'b00, 2'b00, 64'hCAFE);
    chk("swap_atop", aw_cap.atop, 6'b110000);
    chk("same_cnt", rsp_cnt, 1);
    chk("same_cyc", rsp_cyc, 5);
    chk("same_rdata", rsp_dat, 64'hCAFE);

    // LR.D with plain OKAY
    run(4'd0, 64'h3000, 2'd3, 64'h0, 0, 0, 2'b00, 2'b00, 64'hBEEF);
    chk("lr_ar_cnt", ar_cnt, 1);
    chk("lr_aw_cnt", aw_cnt + w_cnt, 0);
    chk("lr_ar_lock", ar_cap.lock, 1);
    chk("lr_ar_size", ar_cap.size, 3'd3);
    chk("lr_ar_len", ar_cap.len, 8'd0);
    chk("lr_ar_burst", ar_cap.burst, 2'b01);
    chk("lr_ar_addr", ar_cap.addr, 64'h3000);
    chk("lr_rdata", rsp_dat, 64'hBEEF);
    chk("lr_err", rsp_e, 0);
    chk("lr_rsp_cyc", rsp_cyc, 3);

    // SC.D success (EXOKAY) then failure (OKAY)
    run(4'd1, 64'h3000, 2'd3, 64'h77, 0, 0, 2'b01, 2'b00, 64'h0);
    chk("sc_aw_lock", aw_cap.lock, 1);
    chk("sc_atop", aw_cap.atop, 6'b000000);
    chk("sc_ok_rdata", rsp_dat, 64'h0);
    chk("sc_ok_err", rsp_e, 0);
    chk("sc_ok_cyc", rsp_cyc, 3);
    run(4'd1, 64'h3000, 2'd3, 64'h77, 0, 0, 2'b00, 2'b00, 64'h0);
    chk("sc_fail_rdata", rsp_dat, 64'h1);
    chk("sc_fail_err", rsp_e, 0);

    // misaligned AMOSWAP.W
    run(4'd2, 64'h1002, 2'd2, 64'h1, 0, 0, 2'b00, 2'b00, 64'h0);
    chk("mis_rsp_cyc", rsp_cyc, 1);
    chk("mis_err", rsp_e, 1);
    chk("mis_rdata", rsp_dat, 64'h0);
    chk("mis_no_axi", aw_cnt + w_cnt + ar_cnt, 0);

    // reserved op
    run(4'd12, 64'h1000, 2'd3, 64'h1, 0, 0, 2'b00, 2'b00, 64'h0);
    chk("rsvd_err", rsp_e, 1);
    chk("rsvd_no_axi", aw_cnt + w_cnt + ar_cnt, 0);

    // SLVERR on B
    run(4'd3, 64'h4000, 2'd3, 64'h1, 0, 0, 2'b10, 2'b00, 64'h55);
    chk("slverr_err", rsp_e, 1);
    chk("slverr_rdata", rsp_dat, 64'h0);
    chk("slverr_cnt", rsp_cnt, 1);

    // reset while AW is stalled
    axi_rsp.aw_ready = 1'b0;
    axi_rsp.w_ready  = 1'b0;
    req_valid_i = 1'b1;
    req_op_i    = 4'd3;
    req_addr_i  = 64'h1000;
    req_size_i  = 2'd2;
    req_wdata_i = 64'h1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("stall_aw_valid", axi_req.aw_valid, 1);
    rst_i = 1'b1;
    #1;
    chk("midrst_aw_valid", axi_req.aw_valid, 0);
    chk("midrst_w_valid", axi_req.w_valid, 0);
    chk("midrst_axi_zero", (axi_req == '0), 1);
    chk("midrst_ready", req_ready_o, 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    axi_rsp.aw_ready = 1'b1;
    axi_rsp.w_ready  = 1'b1;
    @(posedge clk_i); #1;
    chk("after_rst_ready", req_ready_o, 1);
    chk("after_rst_aw_valid", axi_req.aw_valid, 0);
    run(4'd3, 64'h1004, 2'd2, 64'h5, 0, 0, 2'b00, 2'b00, 64'h0000_0009_0000_0000);
    chk("recover_rdata", rsp_dat, 64'h9);
    chk("recover_cyc", rsp_cyc, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
